// File: rtl/coord_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : coord_frame_parser
// Description : Turns the ASCII byte stream from the UART receiver into
//               complete coordinate frames of the form 'S' <dec> ',' <dec>
//               ',' <dec> 'E'. It classifies each byte, accumulates decimal
//               digits, checks the frame structure and presents every good
//               frame as one parallel vector.
// Ports       : clock       - system clock, rising edge
//               reset_n     - asynchronous active-low reset
//               byte_valid  - byte_in carries a received char this cycle
//               byte_in     - ASCII character
//               coords      - last good frame, coord 0 in the LSBs
//               frame_valid - 1-cycle pulse, coords just updated
//               frame_error - 1-cycle pulse, current frame discarded
//               busy        - high while a frame is being collected
//               frame_count - good-frame counter, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module coord_frame_parser #(
    parameter int NUM_COORDS = 3,
    parameter int COORD_W    = 12,
    parameter int MAX_DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_in,
    output logic [NUM_COORDS*COORD_W-1:0] coords,
    output logic                          frame_valid,
    output logic                          frame_error,
    output logic                          busy,
    output logic [7:0]                    frame_count
);

    localparam int IDX_W = (NUM_COORDS > 1) ? $clog2(NUM_COORDS) : 1;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int NXT_W = COORD_W + 4;
    localparam int VEC_W = NUM_COORDS * COORD_W;

    localparam logic [0:0]       C_ST_IDLE  = 1'b0;
    localparam logic [0:0]       C_ST_FIELD = 1'b1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_COORDS - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(MAX_DIGITS);
    localparam logic [NXT_W-1:0] C_VAL_MAX  = {4'b0000, {COORD_W{1'b1}}};

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [COORD_W-1:0] r_acc;
    logic [CNT_W-1:0]   r_digit_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [VEC_W-1:0]   r_shadow;
    logic [VEC_W-1:0]   r_coords;
    logic               r_frame_valid;
    logic               r_frame_error;
    logic [7:0]         r_frame_count;

    logic               w_is_start;
    logic               w_is_end;
    logic               w_is_sep;
    logic               w_is_digit;
    logic [NXT_W-1:0]   w_acc_ext;
    logic [NXT_W-1:0]   w_nxt;
    logic               w_cnt_zero;
    logic               w_idx_last;
    logic               w_in_field;
    logic               w_open;
    logic               w_resync;
    logic               w_digit_ok;
    logic               w_sep_ok;
    logic               w_end_ok;
    logic               w_abort;
    logic [VEC_W-1:0]   w_frame;

    // Byte classification
    always_comb begin
        w_is_start = (byte_in == 8'h53);
        w_is_end   = (byte_in == 8'h45);
        w_is_sep   = (byte_in == 8'h2C);
        w_is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
    end

    // acc*10 + d as two shifts and adds; the widened path cannot overflow,
    // so the range test below sees the true value.
    assign w_acc_ext  = {4'b0000, r_acc};
    assign w_nxt      = (w_acc_ext << 3) + (w_acc_ext << 1)
                      + {{COORD_W{1'b0}}, byte_in[3:0]};
    assign w_cnt_zero = (r_digit_cnt == '0);
    assign w_idx_last = (r_idx == C_IDX_LAST);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (byte_valid) begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_is_start) begin
                        w_state_next = C_ST_FIELD;
                    end
                end
                C_ST_FIELD: begin
                    if (w_is_start) begin
                        w_state_next = C_ST_FIELD;
                    end else if (w_end_ok || w_abort) begin
                        w_state_next = C_ST_IDLE;
                    end
                end
                default: w_state_next = C_ST_IDLE;
            endcase
        end
    end

    // Per-byte actions. Anything inside a frame that is neither a start,
    // an accepted digit, an accepted separator nor an accepted end aborts.
    always_comb begin
        w_in_field = byte_valid && (r_state == C_ST_FIELD);
        w_open     = byte_valid && w_is_start;
        w_resync   = w_in_field && w_is_start;
        w_digit_ok = w_in_field && w_is_digit
                   && (r_digit_cnt != C_CNT_MAX) && (w_nxt <= C_VAL_MAX);
        w_sep_ok   = w_in_field && w_is_sep && !w_cnt_zero && !w_idx_last;
        w_end_ok   = w_in_field && w_is_end && !w_cnt_zero && w_idx_last;
        w_abort    = w_in_field && !w_is_start
                   && !w_digit_ok && !w_sep_ok && !w_end_ok;
    end

    // The last coordinate is still in acc when 'E' arrives; its shadow
    // slot is never written and is replaced here.
    always_comb begin
        w_frame = r_shadow;
        w_frame[(NUM_COORDS-1)*COORD_W +: COORD_W] = r_acc;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc         <= '0;
            r_digit_cnt   <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_coords      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_frame_valid <= w_end_ok;
            r_frame_error <= w_abort | w_resync;
            if (w_open) begin
                r_acc       <= '0;
                r_digit_cnt <= '0;
                r_idx       <= '0;
            end else if (w_digit_ok) begin
                r_acc       <= w_nxt[COORD_W-1:0];
                r_digit_cnt <= r_digit_cnt + CNT_W'(1);
            end else if (w_sep_ok) begin
                r_shadow[r_idx*COORD_W +: COORD_W] <= r_acc;
                r_idx       <= r_idx + IDX_W'(1);
                r_acc       <= '0;
                r_digit_cnt <= '0;
            end
            if (w_end_ok) begin
                r_coords      <= w_frame;
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign coords      = r_coords;
    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign busy        = (r_state == C_ST_FIELD);
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
